spi_arb: RTL and testbench
==========================

Name: spi_arb

Overview:
- Shares the single SPI master between two requesters: client 0 is the A2D interface and client 1 is the inertial sensor interface.
- Latches each client's write request and data, then grants the master round-robin.
- Steers the master's SS_n to the granted client's chip select and routes done and rd_data back to that client.
- A per-client lock keeps the grant across back-to-back transactions, such as the A2D's two-transaction channel read, with a timeout so a stuck lock cannot starve the other client.

Parameters:
- LOCK_TO, 4096: maximum clk cycles the grant may be held in HOLD without a new request from the owner.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- req0  in  1  client 0 write request, single-cycle pulse
- wt_data0  in  16  client 0 command word, sampled with req0
- lock0  in  1  client 0 keeps the grant after its current transaction
- done0  out  1  client 0 transaction complete, 1-cycle pulse
- rd_data0  out  16  client 0 returned word
- req1, wt_data1, lock1, done1, rd_data1: identical for client 1
- m_wrt  out  1  start pulse to the SPI master
- m_wt_data  out  16  command word to the SPI master
- m_done  in  1  SPI master done
- m_rd_data  in  16  SPI master read data
- m_SS_n  in  1  SPI master slave select
- SS0_n  out  1  client 0 device select
- SS1_n  out  1  client 1 device select
- gnt  out  2  one-hot current owner; 00 when no owner
- lock_err  out  1  1-cycle pulse when a lock is revoked by timeout

Behaviour:
- Reset (asynchronous, active-low, single clock clk):
  - Outputs: gnt=00, m_wrt=0, m_wt_data=0, done0=done1=0, rd_data0=rd_data1=0, lock_err=0, SS0_n=SS1_n=1.
  - State: pending flags clear, priority pointer favours client 0, state=IDLE.
  - Reset mid-transfer abandons the transfer; no done is issued. The SPI master shares rst_n.
- Request capture:
  - reqX at a clk edge sets pendX and captures wt_dataX into bufX.
  - reqX while pendX is already set is ignored; bufX is not overwritten.
  - pendX clears on the cycle m_wrt is issued for client X.
- Chip select steering: SSX_n = gnt[X] ? m_SS_n : 1, combinational. The ungranted device's select is always high.
- m_wt_data = buf of the granted client, stable from m_wrt until m_done.
- FSM states: IDLE, XFER, HOLD.
  - IDLE:
    - Only one pend set: grant that client.
    - Both set: grant the client the pointer favours.
    - On grant: gnt is registered, m_wrt pulses for exactly one cycle, next state XFER.
    - Latency: reqX in cycle t, no contention, gives m_wrt and gnt in cycle t+2.
  - XFER:
    - Wait for m_done; m_done in any other state is ignored.
    - On m_done: rd_dataX <= m_rd_data, and doneX pulses the next cycle. rd_dataX holds until the client's next done.
    - If lockX=1 in the m_done cycle: go to HOLD and clear the timeout counter.
    - Else: go to IDLE, gnt=00, pointer favours the other client.
  - HOLD (gnt retained):
    - If pendX (owner): m_wrt, clear pendX, go to XFER. This takes priority over lock deassertion in the same cycle.
    - Else if lockX=0: go to IDLE, pointer favours the other client.
    - Else increment the timeout counter. At LOCK_TO-1: go to IDLE, pulse lock_err, pointer favours the other client.
    - The other client's pend waits in HOLD regardless.
- Owner reqX during XFER sets pendX:
  - with lock: served from HOLD;
  - without lock: re-arbitrated in IDLE, where the pointer now favours the other client.
- Pointer updates only on release of the grant, not per transaction.
- The timeout counter is sized to hold LOCK_TO-1.

Test Plan:
- Single client:
  - Stimulus: reset, then req0 with wt_data0=16'h2000; model m_done 40 cycles after m_wrt with m_rd_data=16'h0ABC.
  - Required: m_wrt at t+2, gnt=01, m_wt_data=16'h2000, SS1_n=1 throughout, done0 one cycle after m_done, rd_data0=16'h0ABC, gnt=00 after.
- Simultaneous requests after reset:
  - Stimulus: req0 and req1 in the same cycle, both unlocked.
  - Required: client 0 served first, then client 1 immediately after from IDLE; done0 precedes done1.
- Lock burst:
  - Stimulus: lock0=1, req0 (16'h2000); req1 pending; after done0, req0 (16'h0000), then lock0=0.
  - Required: second m_wrt goes to client 0 with no client 1 transfer between; after release, client 1 is granted.
- Lock timeout:
  - Stimulus: LOCK_TO=16, lock1 held high with no further req1, req0 pending.
  - Required: lock_err pulses 16 cycles after entering HOLD; client 0 is then granted.
- Protocol edge cases:
  - Stimulus: duplicate req0 while pend0 is set (16'h1111 then 16'h2222).
  - Required: 16'h1111 is transmitted.
  - Stimulus: m_done while IDLE.
  - Required: no done pulses.
  - Stimulus: rst_n asserted mid-XFER.
  - Required: gnt=00, SS0_n=SS1_n=1, no done.

Source files
------------

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between the A2D (client 0) and inertial
// sensor (client 1) interfaces, with per-client grant lock and lock timeout.
module spi_arb #(
    parameter int unsigned LOCK_TO = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] wt_data0,
    input  logic        lock0,
    output logic        done0,
    output logic [15:0] rd_data0,
    input  logic        req1,
    input  logic [15:0] wt_data1,
    input  logic        lock1,
    output logic        done1,
    output logic [15:0] rd_data1,
    output logic        m_wrt,
    output logic [15:0] m_wt_data,
    input  logic        m_done,
    input  logic [15:0] m_rd_data,
    input  logic        m_SS_n,
    output logic        SS0_n,
    output logic        SS1_n,
    output logic [1:0]  gnt,
    output logic        lock_err
);

    localparam int unsigned CntW = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(LOCK_TO - 1);

    typedef enum logic [1:0] {StIdle, StXfer, StHold} state_e;

    state_e          state_q, state_d;
    logic            pend0_q, pend0_d, pend1_q, pend1_d;
    logic [15:0]     buf0_q, buf0_d, buf1_q, buf1_d;
    logic            ptr_q, ptr_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            wrt_q, wrt_d;
    logic [15:0]     wdat_q, wdat_d;
    logic            done0_q, done0_d, done1_q, done1_d;
    logic [15:0]     rd0_q, rd0_d, rd1_q, rd1_d;
    logic            lerr_q, lerr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            owner;
    logic            sel;

    // Owner index is only meaningful while gnt_q is non-zero (XFER/HOLD).
    assign owner = gnt_q[1];

    always_comb begin
        state_d = state_q;
        pend0_d = pend0_q;
        pend1_d = pend1_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        wrt_d   = 1'b0;
        wdat_d  = wdat_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        lerr_d  = 1'b0;
        cnt_d   = cnt_q;
        sel     = 1'b0;

        if (req0 && !pend0_q) begin
            pend0_d = 1'b1;
            buf0_d  = wt_data0;
        end
        if (req1 && !pend1_q) begin
            pend1_d = 1'b1;
            buf1_d  = wt_data1;
        end

        unique case (state_q)
            StIdle: begin
                if (pend0_q || pend1_q) begin
                    // ptr_q only decides under contention.
                    sel     = (pend0_q && pend1_q) ? ptr_q : pend1_q;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    wrt_d   = 1'b1;
                    wdat_d  = sel ? buf1_q : buf0_q;
                    if (sel) pend1_d = 1'b0;
                    else     pend0_d = 1'b0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (m_done) begin
                    if (owner) begin
                        rd1_d   = m_rd_data;
                        done1_d = 1'b1;
                    end else begin
                        rd0_d   = m_rd_data;
                        done0_d = 1'b1;
                    end
                    if (owner ? lock1 : lock0) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 2'b00;
                        ptr_d   = ~owner;
                    end
                end
            end
            StHold: begin
                if (owner ? pend1_q : pend0_q) begin
                    wrt_d   = 1'b1;
                    wdat_d  = owner ? buf1_q : buf0_q;
                    if (owner) pend1_d = 1'b0;
                    else       pend0_d = 1'b0;
                    state_d = StXfer;
                end else if (!(owner ? lock1 : lock0)) begin
                    state_d = StIdle;
                    gnt_d   = 2'b00;
                    ptr_d   = ~owner;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    gnt_d   = 2'b00;
                    ptr_d   = ~owner;
                    lerr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            ptr_q   <= 1'b0;
            gnt_q   <= 2'b00;
            wrt_q   <= 1'b0;
            wdat_q  <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            lerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            wrt_q   <= wrt_d;
            wdat_q  <= wdat_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            lerr_q  <= lerr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign m_wrt     = wrt_q;
    assign m_wt_data = wdat_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rd_data0  = rd0_q;
    assign rd_data1  = rd1_q;
    assign lock_err  = lerr_q;
    assign SS0_n     = gnt_q[0] ? m_SS_n : 1'b1;
    assign SS1_n     = gnt_q[1] ? m_SS_n : 1'b1;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: SPI master model, transaction monitor and directed plus
// randomized scenarios checked against the expected service order.
module tb_spi_arb;

    localparam int unsigned LockTo = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, lock0, req1, lock1;
    logic [15:0] wt_data0, wt_data1;
    logic        done0, done1, m_wrt, SS0_n, SS1_n, lock_err;
    logic [15:0] rd_data0, rd_data1, m_wt_data, m_rd_data;
    logic        mdl_done, inj_done, m_done, m_SS_n;
    logic [1:0]  gnt;

    assign m_done = mdl_done | inj_done;

    spi_arb #(.LOCK_TO(LockTo)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .wt_data0(wt_data0), .lock0(lock0), .done0(done0), .rd_data0(rd_data0),
        .req1(req1), .wt_data1(wt_data1), .lock1(lock1), .done1(done1), .rd_data1(rd_data1),
        .m_wrt(m_wrt), .m_wt_data(m_wt_data), .m_done(m_done), .m_rd_data(m_rd_data),
        .m_SS_n(m_SS_n), .SS0_n(SS0_n), .SS1_n(SS1_n), .gnt(gnt), .lock_err(lock_err)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI master model: m_done md_delay cycles after m_wrt, abandons the transfer on reset.
    bit          md_rand = 1'b0;
    int          md_delay = 40;
    logic [15:0] md_rd = 16'h0;
    int          md_d;
    logic [15:0] md_r;
    bit          md_ok;

    initial begin
        mdl_done = 1'b0;
        m_SS_n = 1'b1;
        m_rd_data = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_n && m_wrt) begin
                md_d = md_rand ? int'($urandom_range(2, 12)) : md_delay;
                md_r = md_rand ? 16'($urandom) : md_rd;
                md_ok = 1'b1;
                for (int i = 0; i < md_d && md_ok; i++) begin
                    @(posedge clk);
                    #1;
                    if (!rst_n) md_ok = 1'b0;
                    else if (i == 0) m_SS_n = 1'b0;
                end
                if (md_ok) begin
                    mdl_done = 1'b1;
                    m_rd_data = md_r;
                    @(posedge clk);
                    #1;
                    mdl_done = 1'b0;
                end
                m_SS_n = 1'b1;
            end
        end
    end

    // Transaction logs filled by the monitor.
    int          wr_cli_q[$];
    logic [15:0] wr_dat_q[$];
    int          wr_cyc_q[$];
    int          dn_cli_q[$];
    int          dn_cyc_q[$];
    int          md_cyc_q[$];
    int          le_cyc_q[$];
    int          dn_cnt[2];
    int          ed_cli_q[$];
    logic [15:0] ed_rd_q[$];
    bit          xfer_act = 1'b0;
    logic [15:0] xfer_data;
    int          lw_cli = 0;
    int          md_last = -10;

    task automatic note_done(input int c, input logic [15:0] rd);
        check("done_expected", 32'(ed_cli_q.size() > 0), 32'd1);
        if (ed_cli_q.size() > 0) begin
            check("done_client", c, ed_cli_q[0]);
            check("done_rd_data", 32'(rd), 32'(ed_rd_q[0]));
            void'(ed_cli_q.pop_front());
            void'(ed_rd_q.pop_front());
        end
        check("done_latency", cyc, md_last + 1);
        dn_cli_q.push_back(c);
        dn_cyc_q.push_back(cyc);
        dn_cnt[c]++;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            xfer_act = 1'b0;
            ed_cli_q.delete();
            ed_rd_q.delete();
        end else begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (gnt[0]) check("ss0_follow", 32'(SS0_n), 32'(m_SS_n));
            else        check("ss0_high", 32'(SS0_n), 32'd1);
            if (gnt[1]) check("ss1_follow", 32'(SS1_n), 32'(m_SS_n));
            else        check("ss1_high", 32'(SS1_n), 32'd1);
            if (xfer_act) check("wt_data_stable", 32'(m_wt_data), 32'(xfer_data));
            check("done_exclusive", 32'(done0 & done1), 32'd0);
            if (m_wrt) begin
                check("wrt_has_gnt", 32'(gnt != 2'b00), 32'd1);
                lw_cli = (gnt == 2'b10) ? 1 : 0;
                wr_cli_q.push_back(lw_cli);
                wr_dat_q.push_back(m_wt_data);
                wr_cyc_q.push_back(cyc);
                xfer_act = 1'b1;
                xfer_data = m_wt_data;
            end else if (m_done && xfer_act) begin
                ed_cli_q.push_back(lw_cli);
                ed_rd_q.push_back(m_rd_data);
                md_cyc_q.push_back(cyc);
                md_last = cyc;
                xfer_act = 1'b0;
            end
            if (done0) note_done(0, rd_data0);
            if (done1) note_done(1, rd_data1);
            if (lock_err) le_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs(input bit r0, input logic [15:0] d0, input bit r1,
                              input logic [15:0] d1);
        req0 = r0;
        wt_data0 = d0;
        req1 = r1;
        wt_data1 = d1;
        tick(1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic clear_logs();
        wr_cli_q.delete();
        wr_dat_q.delete();
        wr_cyc_q.delete();
        dn_cli_q.delete();
        dn_cyc_q.delete();
        md_cyc_q.delete();
        le_cyc_q.delete();
        dn_cnt[0] = 0;
        dn_cnt[1] = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_m_wrt", 32'(m_wrt), 32'd0);
        check("rst_m_wt_data", 32'(m_wt_data), 32'd0);
        check("rst_done", 32'({done1, done0}), 32'd0);
        check("rst_rd_data", 32'({rd_data1, rd_data0}), 32'd0);
        check("rst_lock_err", 32'(lock_err), 32'd0);
        check("rst_ss", 32'({SS1_n, SS0_n}), 32'd3);
        tick(2);
        rst_n = 1'b1;
        clear_logs();
        tick(1);
    endtask

    task automatic wait_dn(input int n, input int budget);
        int k = 0;
        while (dn_cli_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("done_wait", 32'(dn_cli_q.size() >= n), 32'd1);
    endtask

    int          t;
    int          h;
    int          iss[2];
    int          j[2];
    logic [15:0] d0, d1, keep;
    logic [15:0] e_q[2][$];
    bit          r0, r1;

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        wt_data0 = '0; wt_data1 = '0; inj_done = 1'b0;
        dn_cnt[0] = 0; dn_cnt[1] = 0;
        tick(1);

        // Single client, fixed 40-cycle master.
        do_reset();
        md_rand = 1'b0; md_delay = 40; md_rd = 16'h0ABC;
        t = cyc;
        drive_reqs(1'b1, 16'h2000, 1'b0, 16'h0);
        check("t1_no_early_wrt", 32'(m_wrt), 32'd0);
        tick(1);
        check("t1_wrt_cycle", cyc, t + 2);
        check("t1_wrt", 32'(m_wrt), 32'd1);
        check("t1_gnt", 32'(gnt), 32'd1);
        check("t1_wt_data", 32'(m_wt_data), 32'h2000);
        wait_dn(1, 100);
        check("t1_rd_data0", 32'(rd_data0), 32'h0ABC);
        check("t1_gnt_released", 32'(gnt), 32'd0);
        if (md_cyc_q.size() == 1 && dn_cyc_q.size() == 1 && wr_cyc_q.size() == 1) begin
            check("t1_mdone_delay", md_cyc_q[0] - wr_cyc_q[0], 40);
            check("t1_done_after_mdone", dn_cyc_q[0], md_cyc_q[0] + 1);
        end

        // Simultaneous requests after reset.
        do_reset();
        md_rand = 1'b1;
        d0 = 16'($urandom); d1 = 16'($urandom);
        drive_reqs(1'b1, d0, 1'b1, d1);
        wait_dn(2, 100);
        check("t2_wr_count", wr_cli_q.size(), 2);
        if (wr_cli_q.size() == 2 && dn_cli_q.size() == 2 && md_cyc_q.size() == 2) begin
            check("t2_first_cli", wr_cli_q[0], 0);
            check("t2_first_data", 32'(wr_dat_q[0]), 32'(d0));
            check("t2_second_cli", wr_cli_q[1], 1);
            check("t2_second_data", 32'(wr_dat_q[1]), 32'(d1));
            check("t2_back_to_back", wr_cyc_q[1], md_cyc_q[0] + 2);
            check("t2_done_order", dn_cli_q[0] * 2 + dn_cli_q[1], 1);
        end

        // Lock burst: client 0 keeps the grant while client 1 waits.
        do_reset();
        d1 = 16'($urandom);
        lock0 = 1'b1;
        drive_reqs(1'b1, 16'h2000, 1'b0, 16'h0);
        tick(1);
        drive_reqs(1'b0, 16'h0, 1'b1, d1);
        wait_dn(1, 100);
        drive_reqs(1'b1, 16'h0000, 1'b0, 16'h0);
        lock0 = 1'b0;
        wait_dn(3, 200);
        check("t3_wr_count", wr_cli_q.size(), 3);
        if (wr_cli_q.size() == 3) begin
            check("t3_cli_seq", wr_cli_q[0] * 4 + wr_cli_q[1] * 2 + wr_cli_q[2], 1);
            check("t3_data0", 32'(wr_dat_q[0]), 32'h2000);
            check("t3_data1", 32'(wr_dat_q[1]), 32'h0000);
            check("t3_data2", 32'(wr_dat_q[2]), 32'(d1));
        end
        check("t3_no_lock_err", le_cyc_q.size(), 0);

        // Lock timeout: client 1 holds the lock with nothing more to send.
        do_reset();
        d0 = 16'($urandom); d1 = 16'($urandom);
        lock1 = 1'b1;
        drive_reqs(1'b0, 16'h0, 1'b1, d1);
        tick(1);
        drive_reqs(1'b1, d0, 1'b0, 16'h0);
        wait_dn(2, 200);
        lock1 = 1'b0;
        check("t4_lock_err_count", le_cyc_q.size(), 1);
        if (le_cyc_q.size() == 1 && dn_cyc_q.size() == 2 && wr_cli_q.size() == 2) begin
            h = dn_cyc_q[0];
            check("t4_first_cli", wr_cli_q[0], 1);
            check("t4_lock_err_cycle", le_cyc_q[0], h + int'(LockTo));
            check("t4_second_cli", wr_cli_q[1], 0);
            check("t4_second_data", 32'(wr_dat_q[1]), 32'(d0));
            check("t4_second_cycle", wr_cyc_q[1], h + int'(LockTo) + 1);
        end

        // Duplicate request while pending is ignored.
        do_reset();
        drive_reqs(1'b1, 16'h1111, 1'b0, 16'h0);
        drive_reqs(1'b1, 16'h2222, 1'b0, 16'h0);
        wait_dn(1, 100);
        tick(20);
        check("t5_wr_count", wr_cli_q.size(), 1);
        if (wr_cli_q.size() >= 1) check("t5_data", 32'(wr_dat_q[0]), 32'h1111);

        // m_done while IDLE is ignored.
        keep = rd_data0;
        m_rd_data = ~keep;
        inj_done = 1'b1;
        tick(1);
        inj_done = 1'b0;
        tick(5);
        check("t6_no_done", dn_cli_q.size(), 1);
        check("t6_rd_hold", 32'(rd_data0), 32'(keep));

        // Reset in the middle of a transfer.
        do_reset();
        md_rand = 1'b0; md_delay = 30;
        drive_reqs(1'b1, 16'h5A5A, 1'b0, 16'h0);
        tick(6);
        check("t7_in_xfer", 32'(gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_gnt", 32'(gnt), 32'd0);
        check("t7_rst_ss", 32'({SS1_n, SS0_n}), 32'd3);
        tick(2);
        rst_n = 1'b1;
        tick(60);
        check("t7_no_done", dn_cli_q.size(), 0);
        check("t7_no_rewrite", wr_cli_q.size(), 1);

        // Randomized unlocked traffic: each client sends a new word only after its done.
        do_reset();
        md_rand = 1'b1;
        iss[0] = 0; iss[1] = 0;
        e_q[0].delete(); e_q[1].delete();
        for (int k = 0; k < 400; k++) begin
            r0 = (iss[0] == dn_cnt[0]) && ($urandom_range(0, 3) == 0);
            r1 = (iss[1] == dn_cnt[1]) && ($urandom_range(0, 3) == 0);
            d0 = 16'($urandom); d1 = 16'($urandom);
            if (r0) begin iss[0]++; e_q[0].push_back(d0); end
            if (r1) begin iss[1]++; e_q[1].push_back(d1); end
            drive_reqs(r0, d0, r1, d1);
        end
        wait_dn(iss[0] + iss[1], 300);
        j[0] = 0; j[1] = 0;
        foreach (wr_cli_q[i]) begin
            if (j[wr_cli_q[i]] < e_q[wr_cli_q[i]].size())
                check("rnd_data", 32'(wr_dat_q[i]), 32'(e_q[wr_cli_q[i]][j[wr_cli_q[i]]]));
            j[wr_cli_q[i]]++;
        end
        check("rnd_count0", j[0], iss[0]);
        check("rnd_count1", j[1], iss[1]);
        check("rnd_done0", dn_cnt[0], iss[0]);
        check("rnd_done1", dn_cnt[1], iss[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
